// File: rtl/fic0_apb_arbiter_if.sv
// Bus bundle for the FIC_0 APB arbiter: two requester ports (M0, M1) and one downstream slave port.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and slave model.
interface fic0_apb_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M0_PADDR;
    logic                  M0_PSEL;
    logic                  M0_PENABLE;
    logic                  M0_PWRITE;
    logic [DATA_WIDTH-1:0] M0_PWDATA;
    logic [DATA_WIDTH-1:0] M0_PRDATA;
    logic                  M0_PREADY;
    logic                  M0_PSLVERR;

    logic [ADDR_WIDTH-1:0] M1_PADDR;
    logic                  M1_PSEL;
    logic                  M1_PENABLE;
    logic                  M1_PWRITE;
    logic [DATA_WIDTH-1:0] M1_PWDATA;
    logic [DATA_WIDTH-1:0] M1_PRDATA;
    logic                  M1_PREADY;
    logic                  M1_PSLVERR;

    logic [ADDR_WIDTH-1:0] S_PADDR;
    logic                  S_PSEL;
    logic                  S_PENABLE;
    logic                  S_PWRITE;
    logic [DATA_WIDTH-1:0] S_PWDATA;
    logic [DATA_WIDTH-1:0] S_PRDATA;
    logic                  S_PREADY;
    logic                  S_PSLVERR;

    modport slave (
        input  M0_PADDR, M0_PSEL, M0_PENABLE, M0_PWRITE, M0_PWDATA,
        output M0_PRDATA, M0_PREADY, M0_PSLVERR,
        input  M1_PADDR, M1_PSEL, M1_PENABLE, M1_PWRITE, M1_PWDATA,
        output M1_PRDATA, M1_PREADY, M1_PSLVERR,
        output S_PADDR, S_PSEL, S_PENABLE, S_PWRITE, S_PWDATA,
        input  S_PRDATA, S_PREADY, S_PSLVERR
    );

    modport master (
        output M0_PADDR, M0_PSEL, M0_PENABLE, M0_PWRITE, M0_PWDATA,
        input  M0_PRDATA, M0_PREADY, M0_PSLVERR,
        output M1_PADDR, M1_PSEL, M1_PENABLE, M1_PWRITE, M1_PWDATA,
        input  M1_PRDATA, M1_PREADY, M1_PSLVERR,
        input  S_PADDR, S_PSEL, S_PENABLE, S_PWRITE, S_PWDATA,
        output S_PRDATA, S_PREADY, S_PSLVERR
    );
endinterface

// File: rtl/fic0_apb_arbiter.sv
// Two-master, one-slave APB arbiter for the FIC_0 fabric side: round-robin per transfer,
// grant held for the whole transfer, optional timeout abort of slaves that never assert PREADY.
module fic0_apb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RESET,
    fic0_apb_arbiter_if.slave       bus,
    output logic [1:0]              GRANT,
    output logic                    TIMEOUT_ERR
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ABORT  = 2'd3;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_WAIT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_WAIT_C = CNT_W'(LAST_WAIT);

    logic [1:0]            state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      waitCnt_q, waitCnt_d;

    logic                  pick1;
    logic                  timeoutHit;
    logic                  inAccess;
    logic                  inAbort;
    logic                  slaveDone;
    logic                  respValid;
    logic                  respErr;
    logic [DATA_WIDTH-1:0] respData;
    logic                  live0;
    logic                  live1;

    // lastGrant_q: 0 = M0 was served last, 1 = M1; on contention the other one wins.
    assign pick1      = bus.M1_PSEL && (!bus.M0_PSEL || !lastGrant_q);
    assign timeoutHit = TIMEOUT_EN && (waitCnt_q == LAST_WAIT_C);

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        waitCnt_d   = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (bus.M0_PSEL || bus.M1_PSEL) begin
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    lastGrant_d = pick1;
                    addr_d      = pick1 ? bus.M1_PADDR  : bus.M0_PADDR;
                    write_d     = pick1 ? bus.M1_PWRITE : bus.M0_PWRITE;
                    wdata_d     = pick1 ? bus.M1_PWDATA : bus.M0_PWDATA;
                    waitCnt_d   = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A PREADY arriving on the last allowed cycle still counts as a normal completion.
                if (bus.S_PREADY) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (timeoutHit) begin
                    state_d = ABORT;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            waitCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            waitCnt_q   <= waitCnt_d;
        end
    end

    assign inAccess  = (state_q == ACCESS);
    assign inAbort   = (state_q == ABORT);
    assign slaveDone = inAccess && bus.S_PREADY;
    assign respValid = slaveDone || inAbort;
    assign respErr   = inAbort || (slaveDone && bus.S_PSLVERR);
    assign respData  = slaveDone ? bus.S_PRDATA : '0;

    // A requester that has already left its access phase gets nothing back; the result is dropped.
    assign live0 = grant_q[0] && bus.M0_PSEL && bus.M0_PENABLE;
    assign live1 = grant_q[1] && bus.M1_PSEL && bus.M1_PENABLE;

    assign bus.M0_PREADY  = respValid && live0;
    assign bus.M0_PSLVERR = respErr && live0;
    assign bus.M0_PRDATA  = live0 ? respData : '0;
    assign bus.M1_PREADY  = respValid && live1;
    assign bus.M1_PSLVERR = respErr && live1;
    assign bus.M1_PRDATA  = live1 ? respData : '0;

    assign bus.S_PSEL    = (state_q == SETUP) || inAccess;
    assign bus.S_PENABLE = inAccess;
    assign bus.S_PADDR   = addr_q;
    assign bus.S_PWRITE  = write_q;
    assign bus.S_PWDATA  = wdata_q;

    assign GRANT       = grant_q;
    assign TIMEOUT_ERR = inAbort;
endmodule

// File: tb/tb_fic0_apb_arbiter.sv
// Scoreboard bench for fic0_apb_arbiter: per-master expected-response queues filled when a
// transfer starts and drained when the arbiter returns PREADY to that master.
module tb_fic0_apb_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TOUT = 4;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        logic        to;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  GRANT;
    logic        TIMEOUT_ERR;

    exp_t        expQ0[$];
    exp_t        expQ1[$];
    logic [1:0]  grantLog[$];
    logic [1:0]  prevGrant;

    int          compareCount = 0;
    int          mismatchCount = 0;
    int          grantCycles = 0;
    int          toPulses = 0;
    int          done0 = 0;
    int          done1 = 0;
    int          accCnt;
    int          slaveWaits;
    logic [31:0] slaveRdata;
    logic        slaveErr;

    int          cyc, cyc0, cyc0b, cyc1, base;
    logic [1:0]  expOrder[3];

    always #5 CLK = ~CLK;

    fic0_apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fic0_apb_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus),
        .GRANT(GRANT),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    // Slave model: answers after slaveWaits unready ACCESS cycles, returns read data only on reads.
    always @(posedge CLK or posedge RESET) begin
        if (RESET)
            accCnt <= 0;
        else if (bus.S_PSEL && bus.S_PENABLE && !bus.S_PREADY)
            accCnt <= accCnt + 1;
        else
            accCnt <= 0;
    end

    assign bus.S_PREADY  = bus.S_PSEL && bus.S_PENABLE && (accCnt >= slaveWaits);
    assign bus.S_PRDATA  = (bus.S_PREADY && !bus.S_PWRITE) ? slaveRdata : 32'h0;
    assign bus.S_PSLVERR = bus.S_PREADY ? slaveErr : 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic driveMaster(input int m, input logic sel, input logic en,
                               input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        if (m == 0) begin
            bus.M0_PSEL = sel; bus.M0_PENABLE = en; bus.M0_PADDR = addr;
            bus.M0_PWRITE = wr; bus.M0_PWDATA = wdata;
        end else begin
            bus.M1_PSEL = sel; bus.M1_PENABLE = en; bus.M1_PADDR = addr;
            bus.M1_PWRITE = wr; bus.M1_PWDATA = wdata;
        end
    endtask

    function automatic logic readyOf(input int m);
        return (m == 0) ? bus.M0_PREADY : bus.M1_PREADY;
    endfunction

    // Compare one completion against the oldest expectation queued for that master.
    task automatic checkCompletion(input int m);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        logic [33:0] other;
        if (m == 0) begin
            if (expQ0.size() == 0) begin
                checkOutput("unexpected_ready_m0", bus.M0_PREADY, 0);
                return;
            end
            e = expQ0.pop_front();
            rd = bus.M0_PRDATA; er = bus.M0_PSLVERR;
            other = {bus.M1_PREADY, bus.M1_PSLVERR, bus.M1_PRDATA};
        end else begin
            if (expQ1.size() == 0) begin
                checkOutput("unexpected_ready_m1", bus.M1_PREADY, 0);
                return;
            end
            e = expQ1.pop_front();
            rd = bus.M1_PRDATA; er = bus.M1_PSLVERR;
            other = {bus.M0_PREADY, bus.M0_PSLVERR, bus.M0_PRDATA};
        end
        checkOutput($sformatf("prdata_m%0d", m), rd, e.data);
        checkOutput($sformatf("pslverr_m%0d", m), er, e.err);
        checkOutput($sformatf("timeout_err_m%0d", m), TIMEOUT_ERR, e.to);
        checkOutput($sformatf("grant_m%0d", m), GRANT, (m == 0) ? 2'b01 : 2'b10);
        checkOutput($sformatf("s_psel_m%0d", m), bus.S_PSEL, !e.to);
        checkOutput($sformatf("s_paddr_m%0d", m), bus.S_PADDR, e.addr);
        checkOutput($sformatf("s_pwrite_m%0d", m), bus.S_PWRITE, e.wr);
        if (e.wr)
            checkOutput($sformatf("s_pwdata_m%0d", m), bus.S_PWDATA, e.wdata);
        checkOutput($sformatf("other_quiet_m%0d", m), other, 0);
    endtask

    // Monitor on the falling edge, away from the active clock edge.
    always @(negedge CLK) begin
        if (RESET) begin
            prevGrant <= 2'b00;
        end else begin
            if (bus.M0_PREADY) begin
                checkCompletion(0);
                done0 <= done0 + 1;
            end
            if (bus.M1_PREADY) begin
                checkCompletion(1);
                done1 <= done1 + 1;
            end
            if (TIMEOUT_ERR)
                toPulses <= toPulses + 1;
            if (GRANT != 2'b00)
                grantCycles <= grantCycles + 1;
            if (GRANT != 2'b00 && GRANT != prevGrant)
                grantLog.push_back(GRANT);
            prevGrant <= GRANT;
        end
    end

    // One APB transfer from master m; starts just after a rising edge, returns cycles from PSEL to PREADY.
    task automatic applyStimulus(input int m, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wdata, output int cycles);
        exp_t e;
        bit   done;
        e.to    = (slaveWaits >= TOUT);
        e.addr  = addr;
        e.wr    = wr;
        e.wdata = wdata;
        e.err   = e.to ? 1'b1 : slaveErr;
        e.data  = (e.to || wr) ? 32'h0 : slaveRdata;
        if (m == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
        driveMaster(m, 1'b1, 1'b0, addr, wr, wdata);
        cycles = 1;
        @(posedge CLK); #1;
        driveMaster(m, 1'b1, 1'b1, addr, wr, wdata);
        cycles = 2;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (readyOf(m)) begin
                done = 1;
            end else begin
                @(posedge CLK); #1;
                cycles++;
            end
        end
        if (!done)
            checkOutput($sformatf("no_ready_m%0d", m), readyOf(m), 1);
        @(posedge CLK); #1;
        driveMaster(m, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        driveMaster(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        driveMaster(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        slaveWaits = 0;
        slaveRdata = 32'h0;
        slaveErr   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_s_psel", bus.S_PSEL, 0);
        checkOutput("rst_s_penable", bus.S_PENABLE, 0);
        checkOutput("rst_grant", GRANT, 0);
        checkOutput("rst_timeout_err", TIMEOUT_ERR, 0);
        checkOutput("rst_m_ready", {bus.M0_PREADY, bus.M1_PREADY, bus.M0_PSLVERR, bus.M1_PSLVERR}, 0);
        checkOutput("rst_m0_prdata", bus.M0_PRDATA, 0);
        checkOutput("rst_s_paddr", bus.S_PADDR, 0);
        checkOutput("rst_s_pwdata", bus.S_PWDATA, 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        $display("[TB] M0 write, zero-wait slave");
        base = grantCycles;
        applyStimulus(0, 32'h40000010, 1'b1, 32'hA5A5A5A5, cyc);
        checkOutput("t1_latency", cyc, 3);
        checkOutput("t1_grant_cycles", grantCycles - base, 2);

        $display("[TB] M1 read, three slave wait states");
        slaveWaits = 3;
        slaveRdata = 32'h12345678;
        base = done1;
        applyStimulus(1, 32'h40000020, 1'b0, 32'h0, cyc);
        checkOutput("t2_latency", cyc, 6);
        checkOutput("t2_ready_once", done1 - base, 1);

        $display("[TB] contention, M0 re-requests immediately");
        slaveWaits = 0;
        slaveRdata = 32'hDEADBEEF;
        grantLog.delete();
        fork
            begin
                applyStimulus(0, 32'h40000100, 1'b1, 32'h11111111, cyc0);
                applyStimulus(0, 32'h40000104, 1'b0, 32'h0, cyc0b);
            end
            applyStimulus(1, 32'h40000200, 1'b1, 32'h22222222, cyc1);
        join
        expOrder[0] = 2'b01; expOrder[1] = 2'b10; expOrder[2] = 2'b01;
        checkOutput("t3_log_size", grantLog.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < grantLog.size())
                checkOutput($sformatf("t3_grant_%0d", i), grantLog[i], expOrder[i]);
        checkOutput("t3_m1_latency", cyc1, 6);
        checkOutput("t3_m0b_latency", cyc0b, 6);

        $display("[TB] slave never ready, timeout abort");
        slaveWaits = 1000;
        base = toPulses;
        applyStimulus(0, 32'h40000300, 1'b1, 32'h33333333, cyc);
        checkOutput("t4_latency", cyc, 7);
        checkOutput("t4_timeout_pulses", toPulses - base, 1);
        slaveWaits = 0;
        slaveRdata = 32'h0BADF00D;
        applyStimulus(1, 32'h40000304, 1'b0, 32'h0, cyc);
        checkOutput("t4_recover_latency", cyc, 3);

        $display("[TB] ready on the last allowed ACCESS cycle");
        slaveWaits = 3;
        slaveRdata = 32'hCAFEF00D;
        base = toPulses;
        applyStimulus(0, 32'h40000400, 1'b0, 32'h0, cyc);
        checkOutput("t5_latency", cyc, 6);
        checkOutput("t5_timeout_pulses", toPulses - base, 0);

        $display("[TB] reset pulsed during ACCESS");
        slaveWaits = 1000;
        driveMaster(0, 1'b1, 1'b0, 32'h40000500, 1'b0, 32'h0);
        @(posedge CLK); #1;
        driveMaster(0, 1'b1, 1'b1, 32'h40000500, 1'b0, 32'h0);
        @(posedge CLK); #1;
        checkOutput("t6_pre_penable", bus.S_PENABLE, 1);
        #2 RESET = 1'b1;
        #1;
        checkOutput("t6_async_s_psel", bus.S_PSEL, 0);
        checkOutput("t6_async_s_penable", bus.S_PENABLE, 0);
        checkOutput("t6_async_grant", GRANT, 0);
        checkOutput("t6_async_m0_ready", bus.M0_PREADY, 0);
        driveMaster(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        slaveWaits = 0;
        slaveRdata = 32'h5A5A5A5A;
        grantLog.delete();
        fork
            applyStimulus(0, 32'h40000600, 1'b1, 32'h44444444, cyc0);
            applyStimulus(1, 32'h40000700, 1'b0, 32'h0, cyc1);
        join
        checkOutput("t6_log_size", grantLog.size(), 2);
        if (grantLog.size() > 0) checkOutput("t6_first_grant", grantLog[0], 2'b01);
        if (grantLog.size() > 1) checkOutput("t6_second_grant", grantLog[1], 2'b10);
        checkOutput("t6_queues_drained", expQ0.size() + expQ1.size(), 0);

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
